// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encoding, branch condition codes and default counter width.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun      = 2'b00,
      StHazStall = 2'b01,
      StMemWait  = 2'b10,
      StFlush    = 2'b11
   } state_e;

   localparam logic [1:0] CondBez = 2'b11;
   localparam logic [1:0] CondBne = 2'b01;

   localparam int unsigned CntWDefault = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Decodes hazard, branch and memory-wait requests into pipeline register enables,
// flushes and bubbles; keeps stall/flush statistics and a sticky stall watchdog.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = CntWDefault,
   parameter int unsigned MAX_STALL    = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_detected,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             ex_mem_hold,
   output logic             stall_active,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             stall_timeout
);

   localparam int unsigned     RunW      = $clog2(MAX_STALL + 1);
   localparam logic [1:0]      FlushLoad = 2'(FLUSH_CYCLES - 1);
   localparam logic [RunW-1:0] RunLim    = RunW'(MAX_STALL - 1);

   state_e          state_q, state_d;
   logic [1:0]      flush_cnt_q, flush_cnt_d;
   logic            timeout_q, timeout_d;
   logic [RunW-1:0] run_len;
   logic            flush_tail;

   // The cycle with flush_cnt_q == 0 is the FLUSH state's last, non-flushing cycle.
   assign flush_tail = (state_q == StFlush) && (flush_cnt_q != 2'd0);

   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_bubble   = 1'b0;
      ex_mem_hold    = 1'b0;
      state_d        = StRun;
      flush_cnt_d    = 2'd0;
      if (!rst) begin
         if (!mem_ready) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            ex_mem_hold    = 1'b1;
            state_d        = StMemWait;
         end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = StFlush;
            flush_cnt_d  = FlushLoad;
         end else if (hazard_detected) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            state_d        = StHazStall;
         end else if (flush_tail) begin
            if_id_flush = 1'b1;
            state_d     = StFlush;
            flush_cnt_d = flush_cnt_q - 2'd1;
         end
      end
   end

   assign timeout_d = timeout_q | ((state_d != StRun) && (run_len >= RunLim));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         flush_cnt_q <= 2'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_active  = (state_q != StRun);
   assign stall_timeout = timeout_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (~pc_write_en),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (branch_taken & mem_ready),
      .count (flush_count)
   );

   sat_counter #(.WIDTH(RunW)) u_run_len (
      .clk   (clk),
      .rst   (rst),
      .clr   (state_d == StRun),
      .inc   (state_d != StRun),
      .count (run_len)
   );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Drives two controller configurations with tabled, directed and random stimulus
// and compares them against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, hz, br, mr;

   logic        pc_a, ifid_a, fl_a, bub_a, hold_a, act_a, to_a;
   logic [3:0]  sc_a, fc_a;
   logic        pc_b, ifid_b, fl_b, bub_b, hold_b, act_b, to_b;
   logic [15:0] sc_b, fc_b;

   pipeline_stall_controller #(.FLUSH_CYCLES(2), .CNT_W(4), .MAX_STALL(8)) u_a (
      .clk(clk), .rst(rst), .hazard_detected(hz), .branch_taken(br), .mem_ready(mr),
      .pc_write_en(pc_a), .if_id_write_en(ifid_a), .if_id_flush(fl_a),
      .id_ex_bubble(bub_a), .ex_mem_hold(hold_a), .stall_active(act_a),
      .stall_count(sc_a), .flush_count(fc_a), .stall_timeout(to_a)
   );

   pipeline_stall_controller #(.FLUSH_CYCLES(3), .CNT_W(16), .MAX_STALL(64)) u_b (
      .clk(clk), .rst(rst), .hazard_detected(hz), .branch_taken(br), .mem_ready(mr),
      .pc_write_en(pc_b), .if_id_write_en(ifid_b), .if_id_flush(fl_b),
      .id_ex_bubble(bub_b), .ex_mem_hold(hold_b), .stall_active(act_b),
      .stall_count(sc_b), .flush_count(fc_b), .stall_timeout(to_b)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Model state per instance: extra flush cycles owed, counts, stall run length.
   int P_FC[2]  = '{2, 3};
   int P_MAX[2] = '{8, 64};
   int P_SAT[2] = '{15, 65535};
   int m_pend[2], m_sc[2], m_fc[2], m_run[2];
   bit m_act[2], m_to[2];

   typedef struct {
      bit r, h, b, m;
      logic [4:0] e;  // {pc, if_id_we, flush, bubble, hold} for the FLUSH_CYCLES=2 instance
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_act[i] = 0; m_to[i] = 0;
      end
   endtask

   task automatic step(input bit r, input bit h, input bit b, input bit m,
                       output logic [4:0] comb_a);
      logic [4:0] e;
      logic [4:0] ac;
      bit         nact;
      rst = r; hz = h; br = b; mr = m;
      @(negedge clk);
      comb_a = {pc_a, ifid_a, fl_a, bub_a, hold_a};
      for (int i = 0; i < 2; i++) begin
         e = 5'b11000;
         if (!r) begin
            if (!m)            e = 5'b00001;
            else if (b)        e = 5'b11110;
            else if (h)        e = 5'b00010;
            else if (m_pend[i] > 0) e = 5'b11100;
         end
         ac = (i == 0) ? comb_a : {pc_b, ifid_b, fl_b, bub_b, hold_b};
         chk($sformatf("ctrl[%0d]", i), 32'(ac), 32'(e));
         chk($sformatf("stall_active[%0d]", i), (i == 0) ? 32'(act_a) : 32'(act_b), 32'(m_act[i]));
         chk($sformatf("stall_count[%0d]", i), (i == 0) ? 32'(sc_a) : 32'(sc_b), 32'(m_sc[i]));
         chk($sformatf("flush_count[%0d]", i), (i == 0) ? 32'(fc_a) : 32'(fc_b), 32'(m_fc[i]));
         chk($sformatf("timeout[%0d]", i), (i == 0) ? 32'(to_a) : 32'(to_b), 32'(m_to[i]));
         if (r) begin
            m_pend[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_run[i] = 0; m_act[i] = 0; m_to[i] = 0;
         end else begin
            nact = !m || b || h || (m_pend[i] > 0);
            if (!m)                 m_pend[i] = 0;
            else if (b)             m_pend[i] = P_FC[i] - 1;
            else if (h)             m_pend[i] = 0;
            else if (m_pend[i] > 0) m_pend[i] = m_pend[i] - 1;
            if (!e[4] && m_sc[i] < P_SAT[i]) m_sc[i]++;
            if (b && m && m_fc[i] < P_SAT[i]) m_fc[i]++;
            m_run[i] = nact ? m_run[i] + 1 : 0;
            if (nact && m_run[i] >= P_MAX[i]) m_to[i] = 1'b1;
            m_act[i] = nact;
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[14];
   logic [4:0] ca;

   initial begin
      tbl[0]  = '{1, 0, 0, 1, 5'b11000};
      tbl[1]  = '{1, 1, 1, 0, 5'b11000};
      tbl[2]  = '{0, 0, 0, 1, 5'b11000};
      tbl[3]  = '{0, 1, 0, 1, 5'b00010};
      tbl[4]  = '{0, 1, 0, 0, 5'b00001};
      tbl[5]  = '{0, 1, 1, 1, 5'b11110};
      tbl[6]  = '{0, 0, 0, 1, 5'b11100};
      tbl[7]  = '{0, 0, 0, 1, 5'b11000};
      tbl[8]  = '{0, 0, 1, 0, 5'b00001};
      tbl[9]  = '{0, 0, 1, 1, 5'b11110};
      tbl[10] = '{0, 0, 1, 1, 5'b11110};
      tbl[11] = '{0, 0, 0, 1, 5'b11100};
      tbl[12] = '{0, 1, 0, 1, 5'b00010};
      tbl[13] = '{0, 0, 0, 1, 5'b11000};

      rst = 1'b1; hz = 1'b0; br = 1'b0; mr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      foreach (tbl[k]) begin
         step(tbl[k].r, tbl[k].h, tbl[k].b, tbl[k].m, ca);
         chk($sformatf("table row %0d", k), 32'(ca), 32'(tbl[k].e));
      end

      // Three-cycle hazard stall.
      repeat (2) step(1, 0, 0, 1, ca);
      repeat (3) step(0, 1, 0, 1, ca);
      chk("haz3 stall_count", 32'(sc_a), 32'd3);
      step(0, 0, 0, 1, ca);
      chk("haz3 stall_count held", 32'(sc_a), 32'd3);

      // Single branch, then branch racing a hazard.
      step(1, 0, 0, 1, ca);
      step(0, 0, 1, 1, ca);
      repeat (3) step(0, 0, 0, 1, ca);
      chk("branch flush_count a", 32'(fc_a), 32'd1);
      chk("branch flush_count b", 32'(fc_b), 32'd1);
      step(0, 1, 1, 1, ca);
      chk("branch beats hazard ctrl", 32'(ca), 32'(5'b11110));
      chk("branch beats hazard stall_count", 32'(sc_a), 32'd0);

      // Memory wait under a pending hazard, then the hazard stall resumes.
      step(1, 0, 0, 1, ca);
      repeat (4) step(0, 1, 0, 0, ca);
      chk("memwait stall_count", 32'(sc_a), 32'd4);
      step(0, 1, 0, 1, ca);
      chk("memwait resume ctrl", 32'(ca), 32'(5'b00010));
      chk("memwait resume stall_count", 32'(sc_a), 32'd5);

      // Watchdog: MAX_STALL=8 on instance a.
      step(1, 0, 0, 1, ca);
      for (int k = 1; k <= 10; k++) begin
         step(0, 1, 0, 1, ca);
         if (k == 7) chk("timeout before 8th", 32'(to_a), 32'd0);
         if (k == 8) chk("timeout after 8th", 32'(to_a), 32'd1);
      end
      repeat (3) step(0, 0, 0, 1, ca);
      chk("timeout sticky a", 32'(to_a), 32'd1);
      chk("timeout quiet b", 32'(to_b), 32'd0);
      step(1, 0, 0, 1, ca);
      chk("timeout cleared by rst", 32'(to_a), 32'd0);

      // Saturation of the 4-bit stall counter.
      repeat (20) step(0, 1, 0, 1, ca);
      chk("stall_count saturated a", 32'(sc_a), 32'd15);
      chk("stall_count b", 32'(sc_b), 32'd20);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 99) < 35),
              ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 80), ca);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumer end of the hazard interface: takes the hazard-detection stall request, the branch-resolution result and the data-memory ready handshake.
- Drives the pipeline-register write enables, the flush signals and the bubble insertion for the 5-stage MIPS datapath.
- Keeps saturating stall/flush statistics counters and a sticky stall-timeout watchdog for the simulator.
- Sits beside the hazard detection unit in the ID stage and fans out to the PC, IF/ID, ID/EX and EX/MEM registers.

Parameters:
- FLUSH_CYCLES, 1, consecutive cycles the IF/ID register is flushed after a taken branch (range 1..3).
- CNT_W, 16, width of the statistics counters.
- MAX_STALL, 64, consecutive non-RUN cycles before stall_timeout is set.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard_detected  in  1  stall request from hazard detection.
- branch_taken  in  1  branch resolved taken this cycle (COND_BEZ/COND_BNE).
- mem_ready  in  1  data memory has completed or accepted its access; low = multi-cycle wait.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID register write enable.
- if_id_flush  out  1  clears IF/ID to a NOP.
- id_ex_bubble  out  1  forces ID/EX control bits to zero.
- ex_mem_hold  out  1  holds EX/MEM and everything upstream.
- stall_active  out  1  high in any non-RUN state.
- stall_count  out  CNT_W  saturating count of cycles with pc_write_en=0.
- flush_count  out  CNT_W  saturating count of branch flush events.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- FSM states (registered, encoded in package): RUN, HAZ_STALL, MEM_WAIT, FLUSH.
- Priority each cycle: rst > mem_ready=0 > branch_taken > hazard_detected > none.
- Next state:
  - mem_ready=0 -> MEM_WAIT.
  - else branch_taken -> FLUSH, with flush counter loaded to FLUSH_CYCLES-1.
  - else hazard_detected -> HAZ_STALL.
  - else FLUSH with remaining count > 0 -> FLUSH, decrementing the count.
  - else -> RUN.
- Control outputs are combinational decodes of the current inputs under the same priority, giving zero-latency stall:
  - Memory wait (mem_ready=0): pc_write_en=0, if_id_write_en=0, ex_mem_hold=1, id_ex_bubble=0, if_id_flush=0.
  - Branch (branch_taken=1): if_id_flush=1, id_ex_bubble=1, pc_write_en=1 (target loads), if_id_write_en=1.
  - Continuing FLUSH state with no new event: if_id_flush=1, all other outputs at RUN values.
  - Hazard (hazard_detected=1): pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
  - Otherwise: pc_write_en=1, if_id_write_en=1, all other outputs 0.
- A branch_taken during HAZ_STALL wins: flush, no further stall.
- A branch_taken during FLUSH restarts the flush count.
- A branch_taken during MEM_WAIT is ignored; the branch source holds branch_taken until mem_ready.
- stall_active = (state != RUN), registered.
- stall_count increments on every cycle where pc_write_en=0. flush_count increments on each cycle where branch_taken=1 and mem_ready=1. Both saturate at all-ones with no wrap.
- Watchdog: an internal run-length counter increments while the next state is not RUN and clears on RUN. When it reaches MAX_STALL, stall_timeout is set and stays at 1 until rst.
- Reset values:
  - state RUN, all counters 0, stall_timeout 0, stall_active 0.
  - While rst=1 the combinational outputs are forced to RUN values: pc_write_en=1, if_id_write_en=1, others 0.
  - Reset mid-stall or mid-flush returns to RUN in the next cycle with no residual flush.

Decomposition:
- Shared package (pipeline_ctrl_pkg):
  - state encoding constants: RUN=2'b00, HAZ_STALL=2'b01, MEM_WAIT=2'b10, FLUSH=2'b11.
  - COND_BEZ=2'b11 and COND_BNE=2'b01 branch codes.
  - default CNT_W.
- One natural sub-module: sat_counter (parameterised width, inc enable, synchronous clear, saturation), instantiated for stall_count, flush_count and the watchdog run length.

Test Plan:
- rst=1 for 2 cycles, then idle -> pc_write_en=1, if_id_write_en=1, all other outputs 0, stall_count=0, flush_count=0.
- hazard_detected=1 for 3 cycles -> pc_write_en=0 and id_ex_bubble=1 on those exact cycles; stall_count=3; stall_active high from cycle 2 through cycle 4.
- FLUSH_CYCLES=2, branch_taken=1 for 1 cycle -> if_id_flush=1 for 2 consecutive cycles, id_ex_bubble=1 only on the first; flush_count=1.
- hazard_detected=1 and branch_taken=1 together -> flush wins: pc_write_en=1, if_id_flush=1; stall_count unchanged.
- mem_ready=0 for 4 cycles with hazard_detected=1 -> ex_mem_hold=1, id_ex_bubble=0 for those 4 cycles; stall_count=4; then the hazard stall resumes.
- MAX_STALL=8, hazard_detected held high for 10 cycles -> stall_timeout rises after the 8th stall cycle and stays 1 after hazard drops; cleared only by rst.
- CNT_W=4 with 20 stall cycles -> stall_count=15 (saturated, no wrap).
